// File: rtl/tone_player_if.sv
// Note handshake between a song sequencer (master) and tone_player (slave).
interface tone_player_if #(
  parameter int unsigned BEAT_W = 8
);
  logic              note_valid;
  logic              note_ready;
  logic [2:0]        note_deg;
  logic [1:0]        note_oct;
  logic [BEAT_W-1:0] note_beats;

  modport master (
    output note_valid,
    output note_deg,
    output note_oct,
    output note_beats,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_deg,
    input  note_oct,
    input  note_beats,
    output note_ready
  );
endinterface

// File: rtl/tone_player.sv
// Note sequencer and 50% square-wave buzzer driver: one note per handshake, done pulse on completion.
// Optional articulation gap enabled by defining TONE_PLAYER_GAP_EN.
module tone_player #(
  parameter int unsigned BEAT_TICKS = 1_200_000,
  parameter int unsigned BEAT_W     = 8,
  parameter int unsigned OCT_N      = 4,
  parameter int unsigned GAP_TICKS  = 120_000
) (
  input  logic                clk,
  input  logic                rst_n,
  tone_player_if.slave        note_if,
  input  logic                stop,
  output logic                beep,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CNT_W = BEAT_W + $clog2(BEAT_TICKS + 1);
  localparam logic [CNT_W-1:0] TICKS = CNT_W'(BEAT_TICKS);
  localparam logic [2:0] OCT_MAX = 3'(OCT_N - 1);

`ifdef TONE_PLAYER_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  // Tone sounds only while more than TAIL ticks of the budget remain.
  localparam logic [CNT_W-1:0] TAIL = GAP_EN ? CNT_W'(GAP_TICKS) : '0;

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         deg_q, deg_d;
  logic [15:0]        period_q, period_d;
  logic [CNT_W-1:0]   budget_q, budget_d;
  logic [CNT_W-1:0]   dur_cnt_q, dur_cnt_d;
  logic [15:0]        tone_cnt_q, tone_cnt_d;
  logic               done_q, done_d;

  logic               ready;
  logic [1:0]         oct_eff;
  logic               last_tick;
  logic [CNT_W-1:0]   remaining;
  logic [15:0]        half;

  function automatic logic [15:0] base_period(input logic [2:0] d);
    case (d)
      3'd1:    base_period = 16'd45872;
      3'd2:    base_period = 16'd40858;
      3'd3:    base_period = 16'd36408;
      3'd4:    base_period = 16'd34364;
      3'd5:    base_period = 16'd30612;
      3'd6:    base_period = 16'd27273;
      3'd7:    base_period = 16'd24296;
      default: base_period = 16'hFFFF;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    deg_d      = deg_q;
    period_d   = period_q;
    budget_d   = budget_q;
    dur_cnt_d  = dur_cnt_q;
    tone_cnt_d = tone_cnt_q;
    done_d     = 1'b0;
    ready      = 1'b0;

    oct_eff   = ({1'b0, note_if.note_oct} > OCT_MAX) ? OCT_MAX[1:0] : note_if.note_oct;
    // A zero budget still spends exactly one PLAY cycle before completing.
    last_tick = (budget_q == '0) || (dur_cnt_q == budget_q - 1'b1);

    case (state_q)
      IDLE: begin
        ready = !stop;
        if (note_if.note_valid && ready) begin
          state_d    = PLAY;
          deg_d      = note_if.note_deg;
          period_d   = base_period(note_if.note_deg) >> oct_eff;
          budget_d   = CNT_W'(note_if.note_beats) * TICKS;
          dur_cnt_d  = '0;
          tone_cnt_d = '0;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d    = IDLE;
          dur_cnt_d  = '0;
          tone_cnt_d = '0;
        end else if (last_tick) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          dur_cnt_d  = '0;
          tone_cnt_d = '0;
        end else begin
          dur_cnt_d  = dur_cnt_q + 1'b1;
          tone_cnt_d = (tone_cnt_q == period_q - 16'd1) ? '0 : tone_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      deg_q      <= '0;
      period_q   <= '0;
      budget_q   <= '0;
      dur_cnt_q  <= '0;
      tone_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      deg_q      <= deg_d;
      period_q   <= period_d;
      budget_q   <= budget_d;
      dur_cnt_q  <= dur_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      done_q     <= done_d;
    end
  end

  // Output decode uses registered state only; stop takes effect on beep one cycle later.
  always_comb begin
    remaining = budget_q - dur_cnt_q;
    half      = period_q >> 1;
    beep      = (state_q == PLAY) && (deg_q != 3'd0) && (tone_cnt_q < half) && (remaining > TAIL);
    busy      = (state_q == PLAY);
    done      = done_q;
  end

  assign note_if.note_ready = ready;

  a_done_single: assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);
  a_idle_silent: assert property (@(posedge clk) disable iff (!rst_n) (state_q == IDLE) |-> !beep);

endmodule
